kalman_alu_mc: RTL and testbench

KALMAN_ALU_MC -- requirements
Module: kalman_alu_mc

---
 rtl/kalman_alu_mc.sv | 210 +++++++++++++++++++++
 tb/tb_kalman_alu_mc.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/kalman_alu_mc.sv
// Multi-channel 1-D Kalman angle filter with a single shared signed multiplier.
// Optional gyro bias estimation is compiled in with `define KALMAN_BIAS_EST_EN.
module kalman_alu_mc #(
    parameter int          NUM_CH    = 3,
    parameter int          DATA_W    = 16,
    parameter int          DT_W      = 8,
    parameter int          DT_FRAC   = 8,
    parameter int unsigned GAIN      = 16384,
    parameter int unsigned BIAS_GAIN = 256
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     load_gyro,
    input  logic [NUM_CH*DATA_W-1:0] gyro_data,
    input  logic [NUM_CH*DATA_W-1:0] accel_data,
    input  logic [DT_W-1:0]          dt_in,
    input  logic [NUM_CH-1:0]        ch_en,
    output logic [NUM_CH*DATA_W-1:0] angle_out,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun,
    output logic [NUM_CH-1:0]        sat_flag
);

    // Multiplier B operand must hold unsigned dt and an unsigned Q0.16 gain.
    localparam int MB_W   = (DT_W + 1 > 17) ? DT_W + 1 : 17;
    localparam int PROD_W = DATA_W + MB_W;
    localparam int WIDE   = PROD_W + 2;
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic signed [WIDE-1:0] SAT_MAX = {{(WIDE-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [WIDE-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic signed [MB_W-1:0] GAIN_S  = MB_W'(GAIN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_P,
        S_ADD_P,
        S_MUL_U,
        S_ADD_U,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [CH_W-1:0]          ch_idx;
    logic signed [DATA_W-1:0] gyro_q  [NUM_CH];
    logic signed [DATA_W-1:0] accel_q [NUM_CH];
    logic signed [DATA_W-1:0] angle_r [NUM_CH];
    logic [DT_W-1:0]          dt_q;
    logic [NUM_CH-1:0]        en_q;
    logic signed [PROD_W-1:0] prod_r;
    logic signed [DATA_W-1:0] pred_r;

    logic signed [DATA_W-1:0] gyro_c, accel_c, angle_c, bias_c;
    logic signed [WIDE-1:0]   rate_w, pred_w, innov_w, upd_w;
    logic signed [DATA_W-1:0] mul_a;
    logic signed [MB_W-1:0]   mul_b;
    logic signed [PROD_W-1:0] prod;
    logic                     step_sat, bias_clamp;

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [WIDE-1:0] v);
        if (v > SAT_MAX) return SAT_MAX[DATA_W-1:0];
        if (v < SAT_MIN) return SAT_MIN[DATA_W-1:0];
        return v[DATA_W-1:0];
    endfunction

    function automatic logic clamps(input logic signed [WIDE-1:0] v);
        return (v > SAT_MAX) || (v < SAT_MIN);
    endfunction

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_out
        assign angle_out[i*DATA_W +: DATA_W] = angle_r[i];
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            S_IDLE:  if (load_gyro) state_next = S_MUL_P;
            S_MUL_P: state_next = S_ADD_P;
            S_ADD_P: state_next = S_MUL_U;
            S_MUL_U: state_next = S_ADD_U;
            S_ADD_U: state_next = (ch_idx == CH_W'(NUM_CH - 1)) ? S_DONE : S_MUL_P;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------- Bias (optional) ----------------
`ifdef KALMAN_BIAS_EST_EN
    localparam logic signed [MB_W-1:0] BIAS_GAIN_S = MB_W'(BIAS_GAIN);

    logic signed [DATA_W-1:0] bias_r [NUM_CH];
    logic signed [DATA_W-1:0] innov_r;
    logic signed [WIDE-1:0]   bias_w;

    assign bias_c     = bias_r[ch_idx];
    // The multiplier is idle during ADD_U, so it forms innov*BIAS_GAIN there.
    assign bias_w     = WIDE'(bias_c) - (WIDE'(prod) >>> 16);
    assign bias_clamp = clamps(bias_w);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            innov_r <= '0;
            for (int i = 0; i < NUM_CH; i++) bias_r[i] <= '0;
        end else begin
            if (state == S_MUL_U) innov_r <= sat(innov_w);
            if (state == S_ADD_U && en_q[ch_idx]) bias_r[ch_idx] <= sat(bias_w);
        end
    end
`else
    assign bias_c     = '0;
    assign bias_clamp = 1'b0;
`endif

    // ---------------- Datapath ----------------
    always_comb begin
        gyro_c  = gyro_q[ch_idx];
        accel_c = accel_q[ch_idx];
        angle_c = angle_r[ch_idx];
        rate_w  = WIDE'(gyro_c) - WIDE'(bias_c);
        pred_w  = WIDE'(angle_c) + (WIDE'(prod_r) >>> DT_FRAC);
        innov_w = WIDE'(accel_c) - WIDE'(pred_r);
        upd_w   = WIDE'(pred_r) + (WIDE'(prod_r) >>> 16);

        mul_a    = '0;
        mul_b    = '0;
        step_sat = 1'b0;
        case (state)
            S_MUL_P: begin
                mul_a    = sat(rate_w);
                mul_b    = MB_W'(dt_q);
                step_sat = clamps(rate_w);
            end
            S_ADD_P: step_sat = clamps(pred_w);
            S_MUL_U: begin
                mul_a    = sat(innov_w);
                mul_b    = GAIN_S;
                step_sat = clamps(innov_w);
            end
            S_ADD_U: begin
`ifdef KALMAN_BIAS_EST_EN
                mul_a    = innov_r;
                mul_b    = BIAS_GAIN_S;
`endif
                step_sat = clamps(upd_w) | bias_clamp;
            end
            default: ;
        endcase
    end

    assign prod = PROD_W'(mul_a) * PROD_W'(mul_b);

    always_ff @(posedge clk or negedge n_rst) begin
        // NOTE: the snapshot and angle arrays are small register files, reset with everything else
        // so an aborted frame leaves no stale state behind.
        if (!n_rst) begin
            ch_idx   <= '0;
            dt_q     <= '0;
            en_q     <= '0;
            prod_r   <= '0;
            pred_r   <= '0;
            sat_flag <= '0;
            overrun  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                gyro_q[i]  <= '0;
                accel_q[i] <= '0;
                angle_r[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            overrun <= load_gyro && (state != S_IDLE);
            if (state != S_IDLE && en_q[ch_idx] && step_sat) sat_flag[ch_idx] <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (load_gyro) begin
                        ch_idx   <= '0;
                        dt_q     <= dt_in;
                        en_q     <= ch_en;
                        sat_flag <= '0;
                        for (int i = 0; i < NUM_CH; i++) begin
                            gyro_q[i]  <= gyro_data[i*DATA_W +: DATA_W];
                            accel_q[i] <= accel_data[i*DATA_W +: DATA_W];
                        end
                    end
                end
                S_MUL_P: prod_r <= prod;
                S_ADD_P: pred_r <= sat(pred_w);
                S_MUL_U: prod_r <= prod;
                S_ADD_U: begin
                    if (en_q[ch_idx]) angle_r[ch_idx] <= sat(upd_w);
                    ch_idx <= ch_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_kalman_alu_mc.sv
// Self-checking bench for kalman_alu_mc: vector table plus hand sequences, scoreboard queue.
module tb_kalman_alu_mc;

    logic        clk;
    logic        n_rst;
    logic        load_gyro;
    logic [47:0] gyro_data, accel_data;
    logic [7:0]  dt_in;
    logic [2:0]  ch_en;
    logic [47:0] angle_out;
    logic        busy, done, overrun;
    logic [2:0]  sat_flag;

    kalman_alu_mc dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .load_gyro  (load_gyro),
        .gyro_data  (gyro_data),
        .accel_data (accel_data),
        .dt_in      (dt_in),
        .ch_en      (ch_en),
        .angle_out  (angle_out),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun),
        .sat_flag   (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [47:0] gyro;
        logic [47:0] accel;
        logic [7:0]  dt;
        logic [2:0]  en;
        logic [47:0] exp_angle;
        logic [2:0]  exp_sat;
    } vec_t;

    typedef struct {
        string       name;
        logic [47:0] angle;
        logic [2:0]  sat;
    } exp_t;

    vec_t vecs[7];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [47:0] p3(input int a0, input int a1, input int a2);
        return {16'(a2), 16'(a1), 16'(a0)};
    endfunction

    function automatic vec_t mkvec(input string n, input logic [47:0] g, input logic [47:0] a,
                                   input logic [7:0] d, input logic [2:0] e,
                                   input logic [47:0] ea, input logic [2:0] es);
        vec_t v;
        v.name = n; v.gyro = g; v.accel = a; v.dt = d; v.en = e;
        v.exp_angle = ea; v.exp_sat = es;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        load_gyro = 1'b0;
        n_rst     = 1'b0;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    // Drives one accepted load; returns at the first negedge after the accepting edge.
    task automatic start_frame(input vec_t v);
        @(negedge clk);
        gyro_data  = v.gyro;
        accel_data = v.accel;
        dt_in      = v.dt;
        ch_en      = v.en;
        load_gyro  = 1'b1;
        @(negedge clk);
        load_gyro  = 1'b0;
        gyro_data  = 48'h1234_5678_9abc;
        accel_data = 48'hfedc_ba98_7654;
        dt_in      = 8'h77;
        ch_en      = 3'b111;
    endtask

    // Waits for done (bounded), optionally injecting a rejected load at cycle inject_at.
    task automatic wait_done(input int inject_at, output int lat, output int ovr);
        lat = 1;
        ovr = 0;
        while (lat < 60) begin
            if (overrun) ovr++;
            if (done) break;
            load_gyro = (lat == inject_at);
            if (lat == inject_at) gyro_data = p3(-1000, 2000, 3000);
            @(negedge clk);
            lat++;
        end
        load_gyro = 1'b0;
    endtask

    task automatic finish_frame(input string name, input int inject_at);
        int   lat, ovr;
        exp_t e;
        check({name, " busy"}, 64'(busy), 64'd1);
        wait_done(inject_at, lat, ovr);
        check({name, " latency"}, 64'(lat), 64'd13);
        check({name, " overrun_count"}, 64'(ovr), (inject_at > 0) ? 64'd1 : 64'd0);
        if (sb.size() == 0) begin
            check({name, " scoreboard_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check({e.name, " angle_out"}, 64'(angle_out), 64'(e.angle));
            check({e.name, " sat_flag"}, 64'(sat_flag), 64'(e.sat));
        end
        @(negedge clk);
        check({name, " done_width"}, 64'(done), 64'd0);
        check({name, " idle_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input int inject_at);
        exp_t e;
        e.name = v.name; e.angle = v.exp_angle; e.sat = v.exp_sat;
        start_frame(v);
        sb.push_back(e);
        finish_frame(v.name, inject_at);
    endtask

    initial begin
        int lat, ovr, dcount;

        vecs[0] = mkvec("basic",   p3(256, 0, 0),      p3(0, 0, 0),       8'h40, 3'b001, p3(48, 0, 0),      3'b000);
        vecs[1] = mkvec("mask",    p3(256, 256, 256),  p3(0, 0, 0),       8'h40, 3'b010, p3(0, 48, 0),      3'b000);
        vecs[2] = mkvec("sat_hi",  p3(32767, 0, 0),    p3(-32768, 0, 0),  8'hFF, 3'b001, p3(24447, 0, 0),   3'b001);
        vecs[3] = mkvec("all_ch",  p3(-256, 0, 512),   p3(0, 400, 128),   8'h40, 3'b111, p3(-48, 100, 128), 3'b000);
        vecs[4] = mkvec("sat_lo",  p3(-32768, 0, 0),   p3(32767, 0, 0),   8'hFF, 3'b001, p3(-24449, 0, 0),  3'b001);
        vecs[5] = mkvec("ch2_rnd", p3(0, 0, 1000),     p3(0, 0, -100),    8'h10, 3'b100, p3(0, 0, 21),      3'b000);
        vecs[6] = mkvec("none_en", p3(5000, 5000, 5000), p3(-9, 9, 99),   8'hFF, 3'b000, p3(0, 0, 0),       3'b000);

        load_gyro  = 1'b0;
        gyro_data  = '0;
        accel_data = '0;
        dt_in      = '0;
        ch_en      = '0;
        n_rst      = 1'b0;
        @(negedge clk);
        check("reset angle_out", 64'(angle_out), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset sat_flag", 64'(sat_flag), 64'd0);
        check("reset overrun", 64'(overrun), 64'd0);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            run_vec(vecs[i], 0);
        end

        // Sticky saturation is cleared by the next accepted load.
        do_reset();
        run_vec(vecs[2], 0);
        start_frame(vecs[0]);
        check("sat_clear on_accept", 64'(sat_flag), 64'd0);
        wait_done(0, lat, ovr);
        check("sat_clear latency", 64'(lat), 64'd13);
        check("sat_clear at_done", 64'(sat_flag), 64'd0);

        // Rejected load mid-frame must not disturb results or timing.
        do_reset();
        run_vec(vecs[0], 5);

        // Mid-frame reset aborts the frame and clears all outputs at once.
        do_reset();
        run_vec(vecs[3], 0);
        start_frame(vecs[0]);
        repeat (5) @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        void'(sb.size());
        check("abort angle_out", 64'(angle_out), 64'd0);
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort sat_flag", 64'(sat_flag), 64'd0);
        dcount = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 2) n_rst = 1'b1;
            if (done || busy) dcount++;
        end
        check("abort no_done", 64'(dcount), 64'd0);
        run_vec(vecs[0], 0);

        check("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
